riscv_parcel_queue: RTL
=======================

Name: riscv_parcel_queue

Overview:
Parametrised instruction parcel queue between the instruction fetch BIU and pre-decode/decode. It is the next-generation replacement for the fixed two-instruction shift register. Parcels of 32 or 64 bits are split into 16-bit halfword slots and held in a circular buffer of configurable depth. Complete 16-bit (RVC) or 32-bit instructions are delivered under a valid/ready handshake, with PC tracking, per-halfword fetch-exception propagation and flush.

Parameters:
XLEN, 32, data/PC width
PC_INIT, 'h200, PC after reset
PARCEL_SIZE, 32, fetch parcel width; legal values 32 or 64; P = PARCEL_SIZE/16 halfwords
DEPTH, 8, halfword slots; power of two, >= 2*P
HAS_RVC, 1, 1 = 16-bit instructions decoded; 0 = every instruction is 32-bit
EXCEPTION_SIZE, 12, exception vector width

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
flush  input  1  discard queue contents, reload PC
flush_pc  input  XLEN  PC loaded on flush
parcel  input  PARCEL_SIZE  fetched data, halfword 0 at bits [15:0]
parcel_valid  input  P  per-halfword valid; contiguous run ending at bit P-1, or all ones
parcel_misaligned  input  1  misaligned-fetch exception for this parcel
parcel_fault  input  1  access-fault exception for this parcel
parcel_ready  output  1  queue can accept a full parcel this cycle
instr  output  32  head instruction; 16-bit instructions zero-extended
instr_pc  output  XLEN  PC of head instruction
instr_valid  output  1  instr/instr_pc/instr_is16/instr_exception are valid
instr_ready  input  1  consumer accepts head instruction
instr_is16  output  1  head is a 16-bit instruction
instr_exception  output  EXCEPTION_SIZE  exception vector of head instruction
count  output  $clog2(DEPTH+1)  occupied slots

Behaviour:
- Reset (async, rstn low): count=0; read/write pointers=0; instr_pc=PC_INIT; instr_valid=0; instr=INSTR_NOP; instr_exception=0; parcel_ready=1.
- Slot contents: 16-bit data plus 2 exception flags (misaligned, fault) copied from the parcel that delivered the slot.
- Push: occurs when |parcel_valid && parcel_ready. Valid halfwords are written in ascending index order at the write pointer. count and the write pointer advance by popcount(parcel_valid). Pointers wrap modulo DEPTH.
- parcel_ready = (DEPTH - count) >= P. This uses count before any same-cycle pop, so it is conservative; no combinational path from instr_ready.
- Behaviour is undefined if parcel_valid is nonzero while parcel_ready=0. Fetch holds the parcel until ready.
- Head decode: is16 = HAS_RVC && (slot[head][1:0] != 2'b11). need = is16 ? 1 : 2.
- instr_valid = (count >= need) || (count >= 1 && slot[head] has an exception flag).
- Output data:
  - instr = is16 ? {16'h0, slot[head]} : {slot[head+1], slot[head]}.
  - When instr_valid=0, instr = INSTR_NOP and instr_exception = 0.
  - instr_is16 = is16.
- instr_exception: bit CAUSE_MISALIGNED_INSTRUCTION = OR of the misaligned flags of the consumed slots. Bit CAUSE_INSTRUCTION_ACCESS_FAULT = OR of their fault flags. All other bits 0.
- Pop: occurs when instr_valid && instr_ready. Removes min(need, count) slots. instr_pc advances by +2 (is16) or +4 (otherwise), XLEN wrap-around.
- Simultaneous push and pop: count_next = count + pushed - popped.
- Latency: a parcel accepted at edge N drives instr/instr_valid from edge N onward (output is read combinationally from storage; no bypass of the input parcel).
- Flush: synchronous, highest priority over push and pop.
  - count=0, pointers=0, instr_pc=flush_pc.
  - A same-cycle push is discarded.
  - instr_valid=0 in the cycle after the edge.
- Boundary cases:
  - Full (count=DEPTH): parcel_ready=0; a pop that cycle does not raise ready until the next cycle.
  - Empty: instr_valid=0.
  - 32-bit head with count=1 and no exception: waits; instr_valid=0.
  - A halfword pair straddling the wrap point is read correctly.
- Reset asserted mid-operation: immediate return to reset values regardless of clk.

Test Plan:
1. PARCEL_SIZE=32, HAS_RVC=1; push parcel 32'h00A0_0513 (parcel_valid=2'b11) -> next cycle instr_valid=1, instr=32'h00A00513, instr_is16=0, instr_pc='h200; pop -> instr_pc='h204, count=0.
2. Push 32'h4505_4501 (two RVC) -> instr=32'h0000_4501, is16=1, pc='h200; pop -> instr=32'h0000_4505, pc='h202; pop -> count=0, instr_valid=0.
3. Straddle: push {16'h0513, 16'h4501} then {16'hxxxx, 16'h00A0} -> after first pop, instr_valid=0 until second parcel; then instr=32'h00A00513 at pc='h202.
4. DEPTH=8, instr_ready=0, push 4 full parcels -> count=8, parcel_ready=0 after the 4th push; one 32-bit pop -> count=6, parcel_ready=1 on the following cycle; pointers wrap correctly over 20 further instructions.
5. Push with parcel_fault=1, parcel_valid=2'b10, data 16'h0013 -> instr_valid=1 with count=1, instr_exception[CAUSE_INSTRUCTION_ACCESS_FAULT]=1.
6. Flush with flush_pc='h8000_0000 at the same edge as a push and a pop -> count=0, instr_valid=0, pushed data absent; next push presents instr_pc='h8000_0000. rstn pulsed low mid-stream -> instr_pc='h200, count=0 immediately.

Source files
------------

// File: rtl/riscv_parcel_queue.sv
// riscv_parcel_queue: halfword circular buffer that reassembles fetch parcels into 16/32-bit instructions with PC and fault tracking
module riscv_parcel_queue #(
  parameter int                XLEN                           = 32,
  parameter logic [XLEN-1:0]   PC_INIT                        = 'h200,
  parameter int                PARCEL_SIZE                    = 32,
  parameter int                DEPTH                          = 8,
  parameter bit                HAS_RVC                        = 1,
  parameter int                EXCEPTION_SIZE                 = 12,
  parameter int                CAUSE_MISALIGNED_INSTRUCTION   = 0,
  parameter int                CAUSE_INSTRUCTION_ACCESS_FAULT = 1,
  parameter logic [31:0]       INSTR_NOP                      = 32'h0000_0013,
  localparam int               P                              = PARCEL_SIZE / 16,
  localparam int               AW                             = $clog2(DEPTH),
  localparam int               CW                             = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      flush,
  input  logic [XLEN-1:0]           flush_pc,
  input  logic [PARCEL_SIZE-1:0]    parcel,
  input  logic [P-1:0]              parcel_valid,
  input  logic                      parcel_misaligned,
  input  logic                      parcel_fault,
  output logic                      parcel_ready,
  output logic [31:0]               instr,
  output logic [XLEN-1:0]           instr_pc,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic                      instr_is16,
  output logic [EXCEPTION_SIZE-1:0] instr_exception,
  output logic [CW-1:0]             count
);
  logic [15:0]            r_data [DEPTH];
  logic [DEPTH-1:0]       r_mis, r_flt;
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [CW-1:0]          r_count;
  logic [XLEN-1:0]        r_pc;
  logic [CW-1:0]          w_npush, w_npop;
  logic [PARCEL_SIZE-1:0] w_shift;
  logic [AW-1:0]          w_rptr1;
  logic                   w_is16, w_two, w_valid, w_push, w_pop, w_mis, w_flt;
  always_comb begin
    w_npush = '0;
    for (int i = 0; i < P; i++) w_npush = w_npush + CW'(parcel_valid[i]);
  end
  // valid halfwords form a run ending at the top, so drop the invalid low ones
  assign w_shift      = parcel >> (16 * (P - int'(w_npush)));
  assign parcel_ready = (int'(r_count) + P) <= DEPTH;
  assign w_push       = |parcel_valid && parcel_ready && !flush;
  assign w_rptr1      = r_rptr + AW'(1);
  assign w_is16       = HAS_RVC && (r_data[r_rptr][1:0] != 2'b11);
  assign w_two        = !w_is16 && (r_count >= CW'(2));
  assign w_mis        = r_mis[r_rptr] | (w_two & r_mis[w_rptr1]);
  assign w_flt        = r_flt[r_rptr] | (w_two & r_flt[w_rptr1]);
  // a faulting head is released early so the exception is not stuck behind a missing half
  assign w_valid      = (r_count >= (w_is16 ? CW'(1) : CW'(2))) ||
                        ((r_count != '0) && (r_mis[r_rptr] || r_flt[r_rptr]));
  assign w_pop        = w_valid && instr_ready;
  assign w_npop       = w_pop ? (w_two ? CW'(2) : CW'(1)) : '0;
  assign instr        = !w_valid ? INSTR_NOP :
                        w_is16 ? {16'h0, r_data[r_rptr]} : {r_data[w_rptr1], r_data[r_rptr]};
  assign instr_valid  = w_valid;
  assign instr_is16   = w_is16;
  assign instr_pc     = r_pc;
  assign count        = r_count;
  always_comb begin
    instr_exception = '0;
    instr_exception[CAUSE_MISALIGNED_INSTRUCTION]   = w_valid & w_mis;
    instr_exception[CAUSE_INSTRUCTION_ACCESS_FAULT] = w_valid & w_flt;
  end
  always_ff @(posedge clk)
    if (w_push)
      for (int k = 0; k < P; k++)
        if (k < int'(w_npush)) begin
          r_data[r_wptr + AW'(k)] <= w_shift[16*k +: 16];
          r_mis[r_wptr + AW'(k)]  <= parcel_misaligned;
          r_flt[r_wptr + AW'(k)]  <= parcel_fault;
        end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_pc    <= PC_INIT;
    end else if (flush) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_pc    <= flush_pc;
    end else begin
      r_count <= r_count + (w_push ? w_npush : '0) - w_npop;
      r_wptr  <= r_wptr + (w_push ? AW'(w_npush) : '0);
      r_rptr  <= r_rptr + AW'(w_npop);
      if (w_pop) r_pc <= r_pc + (w_is16 ? XLEN'(2) : XLEN'(4));
    end
endmodule
